riscv_mult_arbiter: RTL and testbench

//  Shares the single riscv_mult instance between the core EX stage (core port) and an auxiliary

---
 rtl/riscv_mult_arbiter_pkg.sv | 17 +
 rtl/riscv_mult_arb_prio.sv | 46 ++++
 rtl/riscv_mult_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_riscv_mult_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mult_arbiter_pkg.sv
// Shared types and constants for the riscv_mult arbiter slice.
// Optional operand-tag tracking is enabled with the RISCV_MULT_ARB_DIFT_EN macro.
package riscv_mult_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_CORE = 2'd1,
        BUSY_AUX  = 2'd2
    } mult_arb_state_e;

    localparam logic MULT_ARB_OWNER_CORE = 1'b0;
    localparam logic MULT_ARB_OWNER_AUX  = 1'b1;

    // Wide enough for the largest starvation limit (15).
    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/riscv_mult_arb_prio.sv
// Winner selection between the core and aux requesters, with a starvation
// counter that forces an aux win after STARVE_LIMIT consecutive core issues.
module riscv_mult_arb_prio
    import riscv_mult_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_arb_en,
    input  logic i_core_req,
    input  logic i_aux_req,
    input  logic i_buf_empty,
    output logic o_win_core,
    output logic o_win_aux
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic                    w_starved;
    logic                    w_win_core;
    logic                    w_win_aux;

    // Combinational arbitration: aux wins when idle core or when starved.
    always_comb begin
        w_starved  = (r_starve_cnt == LIMIT);
        w_win_aux  = i_arb_en & i_aux_req & i_buf_empty & (~i_core_req | w_starved);
        w_win_core = i_arb_en & i_core_req & ~w_win_aux;
    end

    assign o_win_core = w_win_core;
    assign o_win_aux  = w_win_aux;

    // Count core issues that bypass a waiting aux; clear when aux stops waiting or wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!i_aux_req || w_win_aux) begin
            r_starve_cnt <= '0;
        end else if (w_win_core && i_buf_empty && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_mult_arbiter.sv
// Shares one riscv_mult between the core EX stage and an auxiliary requester.
// Core has priority, aux is protected from starvation, aux results are buffered.
// Define RISCV_MULT_ARB_DIFT_EN to add operand-tag inputs and result-tag outputs.
module riscv_mult_arbiter
    import riscv_mult_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned OP_WIDTH     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                core_req_i,
    input  logic [OP_WIDTH-1:0] core_op_i,
    input  logic [31:0]         core_op_a_i,
    input  logic [31:0]         core_op_b_i,
    input  logic [31:0]         core_op_c_i,
    input  logic                core_ex_ready_i,
    output logic                core_done_o,
    output logic [31:0]         core_result_o,
    output logic                core_stall_o,
    input  logic                aux_req_i,
    input  logic [OP_WIDTH-1:0] aux_op_i,
    input  logic [31:0]         aux_op_a_i,
    input  logic [31:0]         aux_op_b_i,
    input  logic [31:0]         aux_op_c_i,
    output logic                aux_gnt_o,
    output logic                aux_rvalid_o,
    input  logic                aux_rready_i,
    output logic [31:0]         aux_result_o,
    output logic                mult_en_o,
    output logic [OP_WIDTH-1:0] mult_operator_o,
    output logic [31:0]         mult_op_a_o,
    output logic [31:0]         mult_op_b_o,
    output logic [31:0]         mult_op_c_o,
    output logic                mult_ex_ready_o,
    input  logic [31:0]         mult_result_i,
    input  logic                mult_ready_i
`ifdef RISCV_MULT_ARB_DIFT_EN
    ,
    input  logic                core_tag_a_i,
    input  logic                core_tag_b_i,
    input  logic                core_tag_c_i,
    input  logic                aux_tag_a_i,
    input  logic                aux_tag_b_i,
    input  logic                aux_tag_c_i,
    output logic                core_result_tag_o,
    output logic                aux_result_tag_o
`endif
);

    mult_arb_state_e r_state;
    mult_arb_state_e w_state_nxt;

    logic        r_buf_valid;
    logic [31:0] r_buf_data;

    logic w_win_core;
    logic w_win_aux;
    logic w_own_core;
    logic w_own_aux;
    logic w_owner;
    logic w_core_done;
    logic w_aux_done;

    riscv_mult_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_arb_en    (r_state == IDLE),
        .i_core_req  (core_req_i),
        .i_aux_req   (aux_req_i),
        .i_buf_empty (~r_buf_valid),
        .o_win_core  (w_win_core),
        .o_win_aux   (w_win_aux)
    );

    // Ownership covers both the issue cycle (winner) and the busy state.
    // Core completion also needs core_ex_ready_i so a stalled EX stage keeps the op alive.
    always_comb begin
        w_own_core  = (r_state == BUSY_CORE) | w_win_core;
        w_own_aux   = (r_state == BUSY_AUX) | w_win_aux;
        w_owner     = w_own_aux ? MULT_ARB_OWNER_AUX : MULT_ARB_OWNER_CORE;
        w_core_done = w_own_core & mult_ready_i & core_ex_ready_i;
        w_aux_done  = w_own_aux & mult_ready_i;
    end

    // Next-state logic: one-cycle completions stay in IDLE, others hold the owner.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_win_core && !w_core_done) begin
                    w_state_nxt = BUSY_CORE;
                end else if (w_win_aux && !w_aux_done) begin
                    w_state_nxt = BUSY_AUX;
                end
            end
            BUSY_CORE: if (w_core_done) w_state_nxt = IDLE;
            BUSY_AUX:  if (w_aux_done)  w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Aux result buffer: filled on aux completion, drained by the aux handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (w_aux_done) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= mult_result_i;
        end else if (r_buf_valid && aux_rready_i) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Output muxing; everything is held at zero while reset is asserted.
    always_comb begin
        mult_en_o       = 1'b0;
        mult_operator_o = '0;
        mult_op_a_o     = '0;
        mult_op_b_o     = '0;
        mult_op_c_o     = '0;
        mult_ex_ready_o = 1'b0;
        core_done_o     = 1'b0;
        core_result_o   = '0;
        core_stall_o    = 1'b0;
        aux_gnt_o       = 1'b0;
        aux_rvalid_o    = 1'b0;
        aux_result_o    = '0;
        if (rst_n) begin
            mult_ex_ready_o = 1'b1;
            if (w_own_core) begin
                mult_en_o       = 1'b1;
                mult_operator_o = core_op_i;
                mult_op_a_o     = core_op_a_i;
                mult_op_b_o     = core_op_b_i;
                mult_op_c_o     = core_op_c_i;
                mult_ex_ready_o = core_ex_ready_i;
            end else if (w_owner == MULT_ARB_OWNER_AUX) begin
                mult_en_o       = 1'b1;
                mult_operator_o = aux_op_i;
                mult_op_a_o     = aux_op_a_i;
                mult_op_b_o     = aux_op_b_i;
                mult_op_c_o     = aux_op_c_i;
            end
            core_done_o   = w_core_done;
            core_result_o = mult_result_i;
            core_stall_o  = core_req_i & ~w_own_core;
            aux_gnt_o     = w_aux_done;
            aux_rvalid_o  = r_buf_valid;
            aux_result_o  = r_buf_data;
        end
    end

`ifdef RISCV_MULT_ARB_DIFT_EN
    logic r_buf_tag;

    // Aux result tag travels with the buffered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_tag <= 1'b0;
        end else if (w_aux_done) begin
            r_buf_tag <= aux_tag_a_i | aux_tag_b_i | aux_tag_c_i;
        end
    end

    // Core result tag is combinational, like the core result itself.
    always_comb begin
        core_result_tag_o = 1'b0;
        aux_result_tag_o  = 1'b0;
        if (rst_n) begin
            core_result_tag_o = w_own_core & (core_tag_a_i | core_tag_b_i | core_tag_c_i);
            aux_result_tag_o  = r_buf_tag;
        end
    end
`endif

    // Requesters must hold their request while they own the multiplier.
    a_core_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == BUSY_CORE) |-> core_req_i)
        else $error("core_req_i dropped while core owns the multiplier");
    a_aux_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == BUSY_AUX) |-> aux_req_i)
        else $error("aux_req_i dropped while aux owns the multiplier");

endmodule

// File: tb/tb_riscv_mult_arbiter.sv
// Directed self-checking bench for riscv_mult_arbiter; the bench plays the multiplier.
// With RISCV_MULT_ARB_DIFT_EN defined the tag path is exercised as well.
module tb_riscv_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_i, core_ex_ready_i, core_done_o, core_stall_o;
    logic [2:0]  core_op_i;
    logic [31:0] core_op_a_i, core_op_b_i, core_op_c_i, core_result_o;
    logic        aux_req_i, aux_gnt_o, aux_rvalid_o, aux_rready_i;
    logic [2:0]  aux_op_i;
    logic [31:0] aux_op_a_i, aux_op_b_i, aux_op_c_i, aux_result_o;
    logic        mult_en_o, mult_ex_ready_o, mult_ready_i;
    logic [2:0]  mult_operator_o;
    logic [31:0] mult_op_a_o, mult_op_b_o, mult_op_c_o, mult_result_i;
`ifdef RISCV_MULT_ARB_DIFT_EN
    logic core_tag_a_i, core_tag_b_i, core_tag_c_i;
    logic aux_tag_a_i, aux_tag_b_i, aux_tag_c_i;
    logic core_result_tag_o, aux_result_tag_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_mult_arbiter #(
        .STARVE_LIMIT (4),
        .OP_WIDTH     (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req_i      (core_req_i),
        .core_op_i       (core_op_i),
        .core_op_a_i     (core_op_a_i),
        .core_op_b_i     (core_op_b_i),
        .core_op_c_i     (core_op_c_i),
        .core_ex_ready_i (core_ex_ready_i),
        .core_done_o     (core_done_o),
        .core_result_o   (core_result_o),
        .core_stall_o    (core_stall_o),
        .aux_req_i       (aux_req_i),
        .aux_op_i        (aux_op_i),
        .aux_op_a_i      (aux_op_a_i),
        .aux_op_b_i      (aux_op_b_i),
        .aux_op_c_i      (aux_op_c_i),
        .aux_gnt_o       (aux_gnt_o),
        .aux_rvalid_o    (aux_rvalid_o),
        .aux_rready_i    (aux_rready_i),
        .aux_result_o    (aux_result_o),
        .mult_en_o       (mult_en_o),
        .mult_operator_o (mult_operator_o),
        .mult_op_a_o     (mult_op_a_o),
        .mult_op_b_o     (mult_op_b_o),
        .mult_op_c_o     (mult_op_c_o),
        .mult_ex_ready_o (mult_ex_ready_o),
        .mult_result_i   (mult_result_i),
        .mult_ready_i    (mult_ready_i)
`ifdef RISCV_MULT_ARB_DIFT_EN
        ,
        .core_tag_a_i      (core_tag_a_i),
        .core_tag_b_i      (core_tag_b_i),
        .core_tag_c_i      (core_tag_c_i),
        .aux_tag_a_i       (aux_tag_a_i),
        .aux_tag_b_i       (aux_tag_b_i),
        .aux_tag_c_i       (aux_tag_c_i),
        .core_result_tag_o (core_result_tag_o),
        .aux_result_tag_o  (aux_result_tag_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        core_req_i = 1'b1; core_op_i = '0; core_ex_ready_i = 1'b1;
        core_op_a_i = '0; core_op_b_i = '0; core_op_c_i = '0;
        aux_req_i = 1'b1; aux_op_i = '0; aux_rready_i = 1'b0;
        aux_op_a_i = '0; aux_op_b_i = '0; aux_op_c_i = '0;
        mult_ready_i = 1'b1; mult_result_i = 32'h55;
`ifdef RISCV_MULT_ARB_DIFT_EN
        core_tag_a_i = 1'b0; core_tag_b_i = 1'b0; core_tag_c_i = 1'b0;
        aux_tag_a_i = 1'b0; aux_tag_b_i = 1'b0; aux_tag_c_i = 1'b0;
`endif

        // Reset: requests pending, all outputs must still be zero.
        @(negedge clk); #1;
        chk("rst_mult_en", mult_en_o, 0);
        chk("rst_ex_ready", mult_ex_ready_o, 0);
        chk("rst_stall", core_stall_o, 0);
        chk("rst_done", core_done_o, 0);
        chk("rst_gnt", aux_gnt_o, 0);
        chk("rst_rvalid", aux_rvalid_o, 0);
        @(negedge clk);
        rst_n = 1'b1; core_req_i = 1'b0; aux_req_i = 1'b0; mult_ready_i = 1'b0;
        #1;
        chk("idle_ex_ready", mult_ex_ready_o, 1);
        chk("idle_mult_en", mult_en_o, 0);

        // Test 1: core MUL 2*3, single cycle.
        @(negedge clk);
        core_req_i = 1'b1; core_op_a_i = 32'd2; core_op_b_i = 32'd3;
        mult_result_i = 32'd6; mult_ready_i = 1'b1;
        #1;
        chk("t1_done", core_done_o, 1);
        chk("t1_result", core_result_o, 6);
        chk("t1_stall", core_stall_o, 0);
        chk("t1_mult_en", mult_en_o, 1);
        chk("t1_op_a", mult_op_a_o, 2);
        chk("t1_op_b", mult_op_b_o, 3);

        // Core op held back by EX stage not ready, finishing one cycle later.
        @(negedge clk);
        core_op_a_i = 32'd4; core_op_b_i = 32'd5; core_ex_ready_i = 1'b0;
        mult_result_i = 32'd20;
        #1;
        chk("t1b_done_blocked", core_done_o, 0);
        chk("t1b_ex_ready", mult_ex_ready_o, 0);
        chk("t1b_stall", core_stall_o, 0);
        @(negedge clk);
        core_ex_ready_i = 1'b1;
        #1;
        chk("t1b_done", core_done_o, 1);
        chk("t1b_result", core_result_o, 20);
        chk("t1b_op_a", mult_op_a_o, 4);
        @(negedge clk);
        core_req_i = 1'b0; mult_ready_i = 1'b0;
        #1;
        chk("t1b_idle_en", mult_en_o, 0);

        // Test 2: aux MULH, 4 cycles; core requests from cycle 1.
        @(negedge clk);
        aux_req_i = 1'b1; aux_op_i = 3'd1; aux_op_a_i = 32'd5; aux_op_b_i = 32'd7;
        #1;
        chk("t2_c0_en", mult_en_o, 1);
        chk("t2_c0_operator", mult_operator_o, 1);
        chk("t2_c0_op_a", mult_op_a_o, 5);
        chk("t2_c0_gnt", aux_gnt_o, 0);
        @(negedge clk);
        core_req_i = 1'b1; core_op_a_i = 32'd2; core_op_b_i = 32'd3;
        #1;
        chk("t2_c1_stall", core_stall_o, 1);
        chk("t2_c1_op_a", mult_op_a_o, 5);
        chk("t2_c1_ex_ready", mult_ex_ready_o, 1);
        @(negedge clk); #1;
        chk("t2_c2_stall", core_stall_o, 1);
        @(negedge clk);
        mult_ready_i = 1'b1; mult_result_i = 32'h10;
        #1;
        chk("t2_c3_stall", core_stall_o, 1);
        chk("t2_c3_gnt", aux_gnt_o, 1);
        chk("t2_c3_core_done", core_done_o, 0);
        @(negedge clk);
        aux_req_i = 1'b0; mult_result_i = 32'd6;
        #1;
        chk("t2_c4_core_done", core_done_o, 1);
        chk("t2_c4_op_a", mult_op_a_o, 2);
        chk("t2_c4_stall", core_stall_o, 0);
        chk("t2_c4_rvalid", aux_rvalid_o, 1);
        chk("t2_c4_aux_result", aux_result_o, 32'h10);

        // Test 4: buffer full blocks a second aux request, core still served.
        @(negedge clk);
        core_req_i = 1'b0; mult_ready_i = 1'b0;
        aux_req_i = 1'b1; aux_op_a_i = 32'd9;
        #1;
        chk("t4_blocked_en", mult_en_o, 0);
        chk("t4_blocked_gnt", aux_gnt_o, 0);
        chk("t4_hold_rvalid", aux_rvalid_o, 1);
        @(negedge clk);
        core_req_i = 1'b1; mult_ready_i = 1'b1; mult_result_i = 32'd6;
        #1;
        chk("t4_core_done", core_done_o, 1);
        chk("t4_core_op_a", mult_op_a_o, 2);
        chk("t4_hold_rvalid2", aux_rvalid_o, 1);
        @(negedge clk);
        core_req_i = 1'b0; mult_ready_i = 1'b0; aux_rready_i = 1'b1;
        #1;
        chk("t4_hold_rvalid3", aux_rvalid_o, 1);
        chk("t4_hold_result", aux_result_o, 32'h10);
        chk("t4_still_blocked", mult_en_o, 0);
        @(negedge clk);
        aux_rready_i = 1'b0; mult_ready_i = 1'b1; mult_result_i = 32'h63;
        #1;
        chk("t4_second_gnt", aux_gnt_o, 1);
        chk("t4_second_op_a", mult_op_a_o, 9);
        chk("t4_rvalid_drained", aux_rvalid_o, 0);
        @(negedge clk);
        aux_req_i = 1'b0; mult_ready_i = 1'b0; aux_rready_i = 1'b1;
        #1;
        chk("t4_second_rvalid", aux_rvalid_o, 1);
        chk("t4_second_result", aux_result_o, 32'h63);
        @(negedge clk);
        aux_rready_i = 1'b0;
        #1;
        chk("t4_empty", aux_rvalid_o, 0);

        // Test 3: starvation -- four core wins, aux forced on the fifth.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_req_i = 1'b1; aux_req_i = 1'b1; mult_ready_i = 1'b1; mult_result_i = 32'd6;
            #1;
            chk($sformatf("t3_core_win%0d", i), core_done_o, 1);
            chk($sformatf("t3_no_gnt%0d", i), aux_gnt_o, 0);
        end
        @(negedge clk);
        mult_result_i = 32'h63;
        #1;
        chk("t3_aux_win", aux_gnt_o, 1);
        chk("t3_aux_op_a", mult_op_a_o, 9);
        chk("t3_core_stall", core_stall_o, 1);
        chk("t3_core_done0", core_done_o, 0);
        @(negedge clk);
        mult_result_i = 32'd6; aux_rready_i = 1'b1;
        #1;
        chk("t3_full_core_win", core_done_o, 1);
        chk("t3_buf_result", aux_result_o, 32'h63);
        @(negedge clk);
        aux_rready_i = 1'b0;
        #1;
        chk("t3_cnt_cleared_core", core_done_o, 1);
        chk("t3_cnt_cleared_gnt", aux_gnt_o, 0);
        @(negedge clk);
        core_req_i = 1'b0; aux_req_i = 1'b0; mult_ready_i = 1'b0;
        #1;
        chk("t3_idle", mult_en_o, 0);

        // Test 5: reset during BUSY_AUX aborts the aux op.
        @(negedge clk);
        aux_req_i = 1'b1; aux_op_a_i = 32'd11;
        #1;
        chk("t5_issue", mult_en_o, 1);
        @(negedge clk); #1;
        chk("t5_busy_en", mult_en_o, 1);
        chk("t5_busy_op_a", mult_op_a_o, 11);
        @(negedge clk);
        rst_n = 1'b0; aux_req_i = 1'b0; mult_ready_i = 1'b1;
        #1;
        chk("t5_rst_en", mult_en_o, 0);
        chk("t5_rst_op_a", mult_op_a_o, 0);
        chk("t5_rst_gnt", aux_gnt_o, 0);
        chk("t5_rst_ex_ready", mult_ex_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_post_gnt", aux_gnt_o, 0);
        chk("t5_post_en", mult_en_o, 0);
        chk("t5_post_rvalid", aux_rvalid_o, 0);
        @(negedge clk);
        mult_ready_i = 1'b0;
        #1;
        chk("t5_no_rvalid", aux_rvalid_o, 0);

`ifdef RISCV_MULT_ARB_DIFT_EN
        // Test 6: aux tag follows the buffered result; untagged core result.
        @(negedge clk);
        aux_req_i = 1'b1; aux_tag_b_i = 1'b1; mult_ready_i = 1'b1; mult_result_i = 32'h21;
        #1;
        chk("t6_gnt", aux_gnt_o, 1);
        @(negedge clk);
        aux_req_i = 1'b0; aux_tag_b_i = 1'b0; core_req_i = 1'b1; mult_result_i = 32'd6;
        aux_rready_i = 1'b1;
        #1;
        chk("t6_aux_tag", aux_result_tag_o, 1);
        chk("t6_aux_result", aux_result_o, 32'h21);
        chk("t6_core_done", core_done_o, 1);
        chk("t6_core_tag", core_result_tag_o, 0);
        @(negedge clk);
        core_req_i = 1'b0; mult_ready_i = 1'b0; aux_rready_i = 1'b0;
        #1;
        chk("t6_drained", aux_rvalid_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
